// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver: scans one digit per SCAN_DIV cycles,
// latches the input word once per frame, and optionally blanks leading zeros.
module seg7_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        cpuclk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [2:0]    idx_q;
  logic [31:0]   frame_q;
  logic          load_pend_q;

  logic          tc;
  logic [7:0]    hi_zero;
  logic [3:0]    cur_nib;
  logic          blank;

  function automatic logic [6:0] enc7(input logic [3:0] n);
    case (n)
      4'h0: enc7 = 7'h40;
      4'h1: enc7 = 7'h79;
      4'h2: enc7 = 7'h24;
      4'h3: enc7 = 7'h30;
      4'h4: enc7 = 7'h19;
      4'h5: enc7 = 7'h12;
      4'h6: enc7 = 7'h02;
      4'h7: enc7 = 7'h78;
      4'h8: enc7 = 7'h00;
      4'h9: enc7 = 7'h10;
      4'hA: enc7 = 7'h08;
      4'hB: enc7 = 7'h03;
      4'hC: enc7 = 7'h46;
      4'hD: enc7 = 7'h21;
      4'hE: enc7 = 7'h06;
      default: enc7 = 7'h0E;
    endcase
  endfunction

  assign tc = (div_q == DW'(SCAN_DIV - 1));

  // hi_zero[i]: nibbles i..7 of the latched frame are all zero
  always_comb begin
    hi_zero    = '0;
    hi_zero[7] = (frame_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--)
      hi_zero[i] = (frame_q[4*i +: 4] == 4'h0) && hi_zero[i+1];
  end

  assign cur_nib = frame_q[4*idx_q +: 4];
  assign blank   = blank_lz && (idx_q != 3'd0) && hi_zero[idx_q];

  always_ff @(posedge cpuclk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      load_pend_q <= 1'b1;
      seg_an      <= 8'hFF;
      seg_out     <= 8'hFF;
    end else begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc)
        idx_q <= idx_q + 3'd1;
      // Latch only at frame boundaries so a digit sweep never mixes two words
      if (load_pend_q || (tc && idx_q == 3'd7))
        frame_q <= data_in;
      load_pend_q <= 1'b0;
      seg_an      <= ~(8'b1 << idx_q);
      seg_out     <= {~dp_mask[idx_q], blank ? 7'h7F : enc7(cur_nib)};
    end
  end

endmodule
